// File: rtl/ov7670_pkg.sv
// ov7670_pkg -- shared definitions for the OV7670 capture path.
// Holds the capture sequencer state encoding, the default QVGA geometry
// and the RGB565 pixel width. No ports.

package ov7670_pkg;

    localparam int QVGA_WIDTH  = 320;
    localparam int QVGA_HEIGHT = 240;
    localparam int QVGA_PIXELS = QVGA_WIDTH * QVGA_HEIGHT;  // 76800
    localparam int PIXEL_W     = 16;                        // RGB565

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ARM,
        SEQ_CAPTURE,
        SEQ_DONE
    } seq_state_t;

endpackage

// File: rtl/ov7670_edge_detect.sv
// ov7670_edge_detect -- single-cycle rising-edge detector.
// Ports:
//   pclk   in   clock
//   rst_n  in   asynchronous active-low reset (delayed copy resets to 0)
//   sig    in   level to watch
//   rise   out  sig & ~sig_delayed, combinational from the registered copy

module ov7670_edge_detect (
    input  logic pclk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples its inputs as they were before the edge.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/ov7670_capture_sequencer.sv
// ov7670_capture_sequencer -- arms on a trigger rising edge, discards
// SKIP_FRAMES settling frames, writes one whole frame into the frame buffer
// and reports done, timeout or overflow.
// Ports:
//   pclk, rst_n          clock, asynchronous active-low reset
//   trigger              capture request, acted on at its rising edge in IDLE
//   abort                synchronous return to IDLE, highest priority
//   pixel_data/valid     RGB565 pixel stream from the capture core
//   frame_done           vsync level; its rising edge is a frame boundary
//   wr_en/addr/data      frame-buffer write port, one cycle after the pixel
//   busy                 registered ARM|CAPTURE decode
//   capture_done         one-cycle pulse on frame completion
//   timeout_err          one-cycle pulse when no boundary arrives in time
//   overflow_err         sticky: captured frame had more than FRAME_PIXELS
//   pixel_count          pixels written by the last completed capture
//   short_err            (only with SEQ_SHORT_FRAME_CHECK_EN) last capture
//                        ended with fewer than FRAME_PIXELS pixels
// Build option: define SEQ_SHORT_FRAME_CHECK_EN to add short_err.

module ov7670_capture_sequencer
    import ov7670_pkg::*;
#(
    parameter int FRAME_PIXELS   = QVGA_PIXELS,
    parameter int ADDR_W         = 17,
    parameter int SKIP_FRAMES    = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic               trigger,
    input  logic               abort,
    input  logic [PIXEL_W-1:0] pixel_data,
    input  logic               pixel_valid,
    input  logic               frame_done,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [PIXEL_W-1:0] wr_data,
    output logic               busy,
    output logic               capture_done,
    output logic               timeout_err,
    output logic               overflow_err,
    output logic [ADDR_W:0]    pixel_count
`ifdef SEQ_SHORT_FRAME_CHECK_EN
    , output logic             short_err
`endif
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

    localparam logic [CNT_W-1:0]  FRAME_LIMIT = CNT_W'(FRAME_PIXELS);
    localparam logic [TMO_W-1:0]  TMO_MAX     = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SKIP_W-1:0] SKIP_MAX    = SKIP_W'(SKIP_FRAMES);

    logic trig_rise, frame_start;

    ov7670_edge_detect u_trig_edge (
        .pclk  (pclk),
        .rst_n (rst_n),
        .sig   (trigger),
        .rise  (trig_rise)
    );

    ov7670_edge_detect u_frame_edge (
        .pclk  (pclk),
        .rst_n (rst_n),
        .sig   (frame_done),
        .rise  (frame_start)
    );

    seq_state_t         state, state_nxt;
    logic [SKIP_W-1:0]  skip_cnt, skip_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
    logic [CNT_W-1:0]   addr, addr_nxt;
    logic               wr_en_nxt, busy_nxt, done_nxt, timeout_nxt, overflow_nxt;
    logic [ADDR_W-1:0]  wr_addr_nxt;
    logic [PIXEL_W-1:0] wr_data_nxt;
    logic [ADDR_W:0]    pixel_count_nxt;
    logic               tmo_fire;
`ifdef SEQ_SHORT_FRAME_CHECK_EN
    logic               short_nxt;
`endif

    always_comb begin
        // NOTE: every next-value gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt       = state;
        skip_nxt        = skip_cnt;
        tmo_nxt         = tmo_cnt;
        addr_nxt        = addr;
        wr_en_nxt       = 1'b0;
        wr_addr_nxt     = wr_addr;
        wr_data_nxt     = wr_data;
        done_nxt        = 1'b0;
        timeout_nxt     = 1'b0;
        overflow_nxt    = overflow_err;
        pixel_count_nxt = pixel_count;
`ifdef SEQ_SHORT_FRAME_CHECK_EN
        short_nxt       = short_err;
`endif
        // A boundary arriving on the last allowed cycle still counts as on time.
        tmo_fire = (tmo_cnt == TMO_MAX) && !frame_start;

        if (abort) begin
            state_nxt = SEQ_IDLE;
            skip_nxt  = '0;
            tmo_nxt   = '0;
            addr_nxt  = '0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (trig_rise) begin
                        overflow_nxt = 1'b0;
                        skip_nxt     = '0;
                        tmo_nxt      = '0;
                        addr_nxt     = '0;
`ifdef SEQ_SHORT_FRAME_CHECK_EN
                        short_nxt    = 1'b0;
`endif
                        state_nxt    = SEQ_ARM;
                    end
                end
                SEQ_ARM: begin
                    if (frame_start) begin
                        tmo_nxt = '0;
                        if (skip_cnt == SKIP_MAX) begin
                            addr_nxt  = '0;
                            state_nxt = SEQ_CAPTURE;
                        end else begin
                            skip_nxt = skip_cnt + SKIP_W'(1);
                        end
                    end else if (tmo_fire) begin
                        timeout_nxt = 1'b1;
                        tmo_nxt     = '0;
                        state_nxt   = SEQ_IDLE;
                    end else begin
                        tmo_nxt = tmo_cnt + TMO_W'(1);
                    end
                end
                SEQ_CAPTURE: begin
                    // Pixel is handled before the boundary so a coincident
                    // pixel is written and included in pixel_count.
                    if (pixel_valid && !tmo_fire) begin
                        if (addr < FRAME_LIMIT) begin
                            wr_en_nxt   = 1'b1;
                            wr_addr_nxt = addr[ADDR_W-1:0];
                            wr_data_nxt = pixel_data;
                            addr_nxt    = addr + CNT_W'(1);
                        end else begin
                            overflow_nxt = 1'b1;
                        end
                    end
                    if (frame_start) begin
                        tmo_nxt         = '0;
                        pixel_count_nxt = addr_nxt;
                        done_nxt        = 1'b1;
`ifdef SEQ_SHORT_FRAME_CHECK_EN
                        short_nxt       = (addr_nxt < FRAME_LIMIT);
`endif
                        state_nxt       = SEQ_DONE;
                    end else if (tmo_fire) begin
                        timeout_nxt = 1'b1;
                        tmo_nxt     = '0;
                        state_nxt   = SEQ_IDLE;
                    end else begin
                        tmo_nxt = tmo_cnt + TMO_W'(1);
                    end
                end
                SEQ_DONE: state_nxt = SEQ_IDLE;
                default:  state_nxt = SEQ_IDLE;
            endcase
        end

        busy_nxt = (state_nxt == SEQ_ARM) || (state_nxt == SEQ_CAPTURE);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SEQ_IDLE;
            skip_cnt     <= '0;
            tmo_cnt      <= '0;
            addr         <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            capture_done <= 1'b0;
            timeout_err  <= 1'b0;
            overflow_err <= 1'b0;
            pixel_count  <= '0;
`ifdef SEQ_SHORT_FRAME_CHECK_EN
            short_err    <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            skip_cnt     <= skip_nxt;
            tmo_cnt      <= tmo_nxt;
            addr         <= addr_nxt;
            wr_en        <= wr_en_nxt;
            wr_addr      <= wr_addr_nxt;
            wr_data      <= wr_data_nxt;
            busy         <= busy_nxt;
            capture_done <= done_nxt;
            timeout_err  <= timeout_nxt;
            overflow_err <= overflow_nxt;
            pixel_count  <= pixel_count_nxt;
`ifdef SEQ_SHORT_FRAME_CHECK_EN
            short_err    <= short_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ov7670_capture_sequencer.sv
// tb_ov7670_capture_sequencer -- self-checking bench for the capture
// sequencer with FRAME_PIXELS=16, SKIP_FRAMES=1, TIMEOUT_CYCLES=200.
// Expected writes, counts and pulse timing are derived from the frame
// stream the bench itself generates. Honours SEQ_SHORT_FRAME_CHECK_EN.

module tb_ov7670_capture_sequencer;

    localparam int FP   = 16;
    localparam int AW   = 5;
    localparam int SKIP = 1;
    localparam int TMO  = 200;

    logic          pclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trigger = 1'b0;
    logic          abort = 1'b0;
    logic [15:0]   pixel_data = '0;
    logic          pixel_valid = 1'b0;
    logic          frame_done = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          busy, capture_done, timeout_err, overflow_err;
    logic [AW:0]   pixel_count;
`ifdef SEQ_SHORT_FRAME_CHECK_EN
    logic          short_err;
`endif

    ov7670_capture_sequencer #(
        .FRAME_PIXELS   (FP),
        .ADDR_W         (AW),
        .SKIP_FRAMES    (SKIP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .trigger      (trigger),
        .abort        (abort),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .frame_done   (frame_done),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .capture_done (capture_done),
        .timeout_err  (timeout_err),
        .overflow_err (overflow_err),
        .pixel_count  (pixel_count)
`ifdef SEQ_SHORT_FRAME_CHECK_EN
        , .short_err  (short_err)
`endif
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Observed activity, collected on the falling edge.
    logic [AW+15:0] wr_log[$];
    int n_done = 0, done_cyc = -1, n_tmo = 0, tmo_cyc = -1;

    // Pixels of the frame the model expects to be captured.
    logic [15:0] cap_q[$];
    int rise_cyc = 0, trig_cyc = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (wr_en === 1'b1) wr_log.push_back({wr_addr, wr_data});
        if (capture_done === 1'b1) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (timeout_err === 1'b1) begin
            n_tmo   <= n_tmo + 1;
            tmo_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {wr_en, wr_addr, wr_data, busy, capture_done, timeout_err,
                overflow_err, pixel_count};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic pulse_trigger();
        trigger  = 1'b1;
        trig_cyc = cyc;
        tick();
        trigger  = 1'b0;
        tick();
    endtask

    task automatic vsync();
        frame_done = 1'b1;
        rise_cyc   = cyc;
        tick(3);
        frame_done = 1'b0;
        tick();
    endtask

    task automatic send_pixels(input int n, input bit ramp, input bit record);
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, 2));
            pixel_data  = ramp ? 16'h1000 + 16'(i) : 16'($urandom);
            pixel_valid = 1'b1;
            if (record) cap_q.push_back(pixel_data);
            tick();
            pixel_valid = 1'b0;
        end
    endtask

    // Model: the first FP pixels of the captured frame land at addresses 0.. in order.
    task automatic check_writes(input string tag, input int base);
        int n_exp, n_act;
        n_exp = (cap_q.size() < FP) ? cap_q.size() : FP;
        n_act = wr_log.size() - base;
        check({tag, "_nwr"}, n_act, n_exp);
        for (int i = 0; i < n_exp && i < n_act; i++)
            check({tag, "_wr"}, wr_log[base + i], {AW'(i), cap_q[i]});
    endtask

    // Trigger, SKIP discarded frames, one captured frame, closing boundary, idle tail.
    task automatic run_capture(input string tag, input int cap_n, input bit ramp);
        int wb, db, tb0, n_exp;
        wb  = wr_log.size();
        db  = n_done;
        tb0 = n_tmo;
        cap_q.delete();
        pulse_trigger();
        for (int f = 0; f <= SKIP; f++) begin
            vsync();
            if (f < SKIP) send_pixels(1 + int'($urandom_range(0, FP)), 1'b0, 1'b0);
            else          send_pixels(cap_n, ramp, 1'b1);
        end
        vsync();
        send_pixels(4, 1'b0, 1'b0);
        tick(2);
        n_exp = (cap_n < FP) ? cap_n : FP;
        check_writes(tag, wb);
        check({tag, "_done_cnt"}, n_done - db, 1);
        check({tag, "_done_cyc"}, done_cyc, rise_cyc + 1);
        check({tag, "_tmo_cnt"}, n_tmo - tb0, 0);
        check({tag, "_pix_cnt"}, pixel_count, n_exp);
        check({tag, "_ovf"}, overflow_err, (cap_n > FP));
        check({tag, "_busy"}, busy, 0);
`ifdef SEQ_SHORT_FRAME_CHECK_EN
        check({tag, "_short"}, short_err, (cap_n < FP));
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, db, tb0;
        bit seen;

        // Reset state
        tick(3);
        check("reset_outs", outs(), 0);
        rst_n = 1'b1;
        tick(2);
        check("post_reset_outs", outs(), 0);

        // Normal capture with ramp data, then a short frame
        run_capture("normal", FP, 1'b1);
        run_capture("short", 10, 1'b0);

        // Overflow: 20 pixels, flag held until the next trigger
        run_capture("overflow", 20, 1'b0);
        tick(10);
        check("ovf_held", overflow_err, 1);

        // Timeout: trigger then no frame boundary
        db  = n_done;
        tb0 = n_tmo;
        pulse_trigger();
        check("ovf_cleared", overflow_err, 0);
        check("tmo_busy", busy, 1);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (n_tmo != tb0) seen = 1'b1;
        end
        check("tmo_seen", seen, 1);
        tick(2);
        check("tmo_cnt", n_tmo - tb0, 1);
        check("tmo_cyc", tmo_cyc, trig_cyc + 1 + TMO);
        check("tmo_no_done", n_done - db, 0);
        check("tmo_idle_busy", busy, 0);
        pulse_trigger();
        check("retrig_after_tmo", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_arm_busy", busy, 0);
        tick(2);

        // Abort after 5 captured pixels
        wb = wr_log.size();
        db = n_done;
        cap_q.delete();
        pulse_trigger();
        vsync();
        send_pixels(3, 1'b0, 1'b0);
        vsync();
        send_pixels(5, 1'b0, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        send_pixels(6, 1'b0, 1'b0);
        vsync();
        tick(3);
        check_writes("abort", wb);
        check("abort_no_done", n_done - db, 0);

        // Trigger pulses during CAPTURE are ignored
        wb = wr_log.size();
        db = n_done;
        cap_q.delete();
        pulse_trigger();
        vsync();
        send_pixels(4, 1'b0, 1'b0);
        vsync();
        send_pixels(6, 1'b0, 1'b1);
        pulse_trigger();
        send_pixels(4, 1'b0, 1'b1);
        pulse_trigger();
        send_pixels(6, 1'b0, 1'b1);
        vsync();
        tick(3);
        check_writes("retrig", wb);
        check("retrig_done", n_done - db, 1);
        check("retrig_pix_cnt", pixel_count, FP);

        // Randomised frame lengths around the boundary
        repeat (4) run_capture("rand", int'($urandom_range(0, FP + 4)), 1'b0);

        // Reset mid-frame
        pulse_trigger();
        vsync();
        send_pixels(3, 1'b0, 1'b0);
        vsync();
        send_pixels(6, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", outs(), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("rst_after_outs", outs(), 0);
        wb = wr_log.size();
        db = n_done;
        vsync();
        send_pixels(8, 1'b0, 1'b0);
        vsync();
        tick(3);
        check("rst_idle_writes", wr_log.size() - wb, 0);
        check("rst_idle_done", n_done - db, 0);
        check("rst_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ov7670_capture_sequencer.md
Name: ov7670_capture_sequencer

Overview:
- Controls capture of a single frame from the OV7670 pixel stream, for use with the PIR-triggered camera path on the Zynq-7020.
- Sits between the byte-pair capture core (pixel_data/pixel_valid/frame_done) and the frame-buffer write port.
- On a trigger it discards the settling frames, writes exactly one whole frame into the buffer, and reports done, timeout or overflow.

Parameters:
- FRAME_PIXELS, 76800, number of pixels written per captured frame (320x240).
- ADDR_W, 17, width of the frame-buffer address; 2^ADDR_W must be at least FRAME_PIXELS.
- SKIP_FRAMES, 2, number of whole frames discarded after arming before capture begins; 0 is legal.
- TIMEOUT_CYCLES, 2000000, pclk cycles allowed between frame boundaries in ARM/CAPTURE before timeout.

Ports:
- pclk  in  1  sensor pixel clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- trigger  in  1  capture request (PIR); acted on at its rising edge.
- abort  in  1  synchronous abort; returns the block to IDLE.
- pixel_data  in  16  RGB565 pixel from the capture core.
- pixel_valid  in  1  one-cycle strobe marking pixel_data valid.
- frame_done  in  1  high for the whole vsync interval.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  frame-buffer write address.
- wr_data  out  16  frame-buffer write data.
- busy  out  1  high in ARM and CAPTURE.
- capture_done  out  1  one-cycle pulse when a frame is complete.
- timeout_err  out  1  one-cycle pulse when a timeout fires.
- overflow_err  out  1  sticky flag: more than FRAME_PIXELS pixels arrived.
- pixel_count  out  ADDR_W+1  pixels written in the last capture.

Behaviour:
- Reset state: all outputs 0; state IDLE; all counters 0; trig_q 0; fd_q 0.
- Edge events, each decided by a 1-cycle delayed copy of its input:
  - trig_rise = trigger & ~trig_q.
  - frame_start = frame_done & ~fd_q.
- States: IDLE, ARM, CAPTURE, DONE. abort moves any state to IDLE next cycle, with no pulses and counters cleared; abort has priority over every other event.
- IDLE:
  - On trig_rise: clear overflow_err, skip_cnt, tmo_cnt and addr; go to ARM.
  - trigger in any other state is ignored.
- ARM: on each frame_start:
  - If skip_cnt == SKIP_FRAMES: go to CAPTURE with addr=0.
  - Otherwise skip_cnt++.
  - With SKIP_FRAMES=0, the first frame boundary starts capture.
- CAPTURE, per pixel_valid:
  - If addr < FRAME_PIXELS: next cycle wr_en=1, wr_addr=addr, wr_data=pixel_data; then addr++. Write latency is 1 cycle.
  - If addr == FRAME_PIXELS: the pixel is dropped and overflow_err is set to 1.
- CAPTURE, on frame_start: pixel_count<=addr; go to DONE.
- pixel_valid and frame_start never coincide from the capture core. If they do, the pixel is written first, then the frame_start transition is taken in the same cycle, and pixel_count includes that pixel.
- DONE: capture_done=1 for exactly one cycle, then go to IDLE. wr_en is 0 in every state except the cycle after an accepted pixel.
- Timeout:
  - tmo_cnt increments each cycle in ARM and CAPTURE and clears on frame_start.
  - When it reaches TIMEOUT_CYCLES-1: timeout_err pulses for 1 cycle, the state goes to IDLE, and capture_done is not asserted.
- busy is a registered decode of ARM|CAPTURE.
- The counter width is clog2(TIMEOUT_CYCLES).
- Reset mid-capture: state returns to IDLE immediately; the partial buffer contents are undefined.

Optional Feature:
- Macro: SEQ_SHORT_FRAME_CHECK_EN.
- Defined:
  - Adds output short_err (1 bit, reset 0).
  - Set in the DONE entry cycle when addr < FRAME_PIXELS; cleared on the next accepted trigger.
  - capture_done still pulses.
- Undefined: the port and its logic are absent; short frames complete silently, and pixel_count is the only indication.

Decomposition:
- Shared package ov7670_pkg holds:
  - The state enum (SEQ_IDLE, SEQ_ARM, SEQ_CAPTURE, SEQ_DONE).
  - Default QVGA geometry constants (320, 240, 76800).
  - The pixel width constant 16.
- One sub-module is natural: ov7670_edge_detect (rising-edge detector, reset to 0), instantiated for trigger and frame_done.

Test Plan (bench parameters: FRAME_PIXELS=16, SKIP_FRAMES=1, TIMEOUT_CYCLES=200):
- Normal capture:
  - Stimulus: trigger pulse, then 3 frames of 16 pixels each (data 0x1000+i).
  - Expect: frame 1 skipped; frame 2 written at addr 0..15 with data 0x1000..0x100F; capture_done 1 cycle after the third frame_done rise; pixel_count=16; busy low afterwards.
- Overflow:
  - Stimulus: captured frame carries 20 pixels.
  - Expect: only 16 writes; overflow_err=1 held until the next trigger; capture_done still pulses.
- Timeout:
  - Stimulus: trigger with no frame_done for 200 cycles.
  - Expect: timeout_err pulse at cycle 200; no capture_done; state IDLE; trigger accepted again.
- Abort:
  - Stimulus: assert abort after 5 captured pixels.
  - Expect: no further wr_en; no capture_done; busy=0 next cycle.
- Retrigger and reset:
  - Stimulus: trigger pulses during CAPTURE; then rst_n low mid-frame.
  - Expect: the trigger pulses are ignored; after reset all outputs are 0 and the state is IDLE.
- Short frame (SEQ_SHORT_FRAME_CHECK_EN defined):
  - Stimulus: captured frame carries 10 pixels.
  - Expect: short_err=1; pixel_count=10.
